// File: rtl/if_fetch_pkg.sv
// Shared widths and helpers for the instruction fetch unit.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_SIZE = 64;
  localparam int unsigned INST_SIZE      = 32;
  localparam int unsigned FETCH_DEPTH    = 2;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-unit bus: PC register side, instruction memory channel and decode channel.
interface if_fetch_if
  import if_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_SIZE,
  parameter int unsigned INST_W = INST_SIZE
) ();

  logic              pc_hold;
  logic [ADDR_W-1:0] pc;
  logic              flush;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              imem_rsp_err;

  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic              id_fault;

  modport master (
    input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, id_ready,
    output pc_hold, imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, id_fault
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, id_ready,
    input  pc_hold, imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, id_fault
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear.
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i & (cnt_q != '0);
  // A push into a full FIFO is allowed only when the same cycle pops.
  assign push_ok = push_i & ((cnt_q != CNT_W'(DEPTH)) | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: issues imem requests under a shared credit, tracks request PCs,
// buffers in-order responses for decode and discards responses made stale by a flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_SIZE,
  parameter int unsigned INST_W = INST_SIZE,
  parameter int unsigned DEPTH  = FETCH_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  if_fetch_if.master bus
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = INST_W + ADDR_W + 1;

  logic [CNT_W-1:0]  out_cnt, fifo_cnt;
  logic [CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ENT_W-1:0]  buf_in, buf_out;
  logic              id_valid_w, deq, credit, req_valid, req_fire;
  logic              retire, drop, buf_push;
  logic [SUM_W-1:0]  occupancy;

  assign id_valid_w = (fifo_cnt != '0);
  assign deq        = id_valid_w & bus.id_ready;

  // Discarded in-flight requests still hold credit until their responses retire.
  assign occupancy = SUM_W'(out_cnt) + SUM_W'(fifo_cnt) - SUM_W'(deq);
  assign credit    = occupancy < SUM_W'(DEPTH);
  assign req_valid = rst & credit & ~bus.flush;
  assign req_fire  = req_valid & bus.imem_req_ready;

  assign retire   = bus.imem_rsp_valid & (out_cnt != '0);
  assign drop     = (disc_cnt_q != '0) | bus.flush;
  assign buf_push = retire & ~drop;
  assign buf_in   = {bus.imem_rsp_data, rsp_pc, bus.imem_rsp_err};

  always_comb begin
    disc_cnt_d = disc_cnt_q;
    if (bus.flush) begin
      disc_cnt_d = out_cnt - CNT_W'(retire);
    end else if (retire && (disc_cnt_q != '0)) begin
      disc_cnt_d = disc_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) disc_cnt_q <= '0;
    else      disc_cnt_q <= disc_cnt_d;
  end

  if_fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .push_i  (req_fire),
    .pop_i   (retire),
    .data_i  (bus.pc),
    .data_o  (rsp_pc),
    .count_o (out_cnt)
  );

  if_fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.flush),
    .push_i  (buf_push),
    .pop_i   (deq),
    .data_i  (buf_in),
    .data_o  (buf_out),
    .count_o (fifo_cnt)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc;
  assign bus.pc_hold        = ~req_fire;

  assign bus.id_valid = id_valid_w;
  assign bus.id_inst  = id_valid_w ? buf_out[ENT_W-1 -: INST_W] : '0;
  assign bus.id_pc    = id_valid_w ? buf_out[ADDR_W:1] : '0;
  assign bus.id_fault = id_valid_w & buf_out[0];

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: environment models the PC register and a fixed-latency memory;
// a monitor checks every decode handshake against an expected-instruction queue.
module tb_if_fetch;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } pend_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  logic clk;
  logic rst;
  if_fetch_if #(.ADDR_W(64), .INST_W(32)) bus ();

  if_fetch #(.ADDR_W(64), .INST_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          budget = 0;
  int          fires = 0;
  int          run = 0;
  int          run_max = 0;
  bit          rst_r = 1'b0;
  bit          flush_r = 1'b0;
  bit          id_ready_r = 1'b1;
  bit          stall_r = 1'b0;
  bit          err_en = 1'b0;
  bit          data_mode = 1'b0;
  bit          prev_adv = 1'b0;
  bit          prev_flush = 1'b0;
  logic [63:0] pc_r = 64'h8000_0000;
  logic [63:0] flush_tgt = '0;
  pend_t       pend[$];
  exp_t        exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] inst, input logic fault);
    exp_t e;
    e.pc = pc; e.inst = inst; e.fault = fault;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] addr);
    if (data_mode) return {addr[15:0], 16'h0013};
    return 32'h0000_0013;
  endfunction

  // One clock cycle of environment: drive at the falling edge, sample handshakes 1 ns later.
  task automatic step();
    pend_t p;
    @(negedge clk);
    cyc++;
    rst = rst_r;
    if (prev_flush)    pc_r = flush_tgt;
    else if (prev_adv) pc_r = pc_r + 64'd4;
    bus.pc             = pc_r;
    bus.flush          = flush_r;
    bus.id_ready       = id_ready_r;
    bus.imem_req_ready = (budget > 0) && !stall_r;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    if (!rst_r) begin
      pend.delete();
      bus.imem_rsp_valid = cyc[0];
      bus.imem_rsp_data  = $urandom;
      bus.imem_rsp_err   = cyc[0];
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_data(p.addr);
      bus.imem_rsp_err   = err_en && (p.addr == 64'h8000_0008);
    end
    #1;
    if (rst_r && bus.imem_req_valid && bus.imem_req_ready) begin
      p.due  = cyc + lat;
      p.addr = bus.imem_req_addr;
      pend.push_back(p);
      budget--;
      fires++;
    end
    prev_adv   = rst_r && !bus.pc_hold;
    prev_flush = flush_r;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk({name, " left undelivered"}, 64'(exp_q.size()), 64'd0);
    repeat (3) step();
  endtask

  // Monitor: every decode handshake is compared with the head of the expected queue.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst && bus.id_valid) run++;
    else                     run = 0;
    if (run > run_max) run_max = run;
    if (rst && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected id output: got pc %h inst %h, expected none", bus.id_pc, bus.id_inst);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_inst", 64'(bus.id_inst), 64'(e.inst));
        chk("id_fault", 64'(bus.id_fault), 64'(e.fault));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.pc = 64'h8000_0000;
    bus.flush = 1'b0;
    bus.id_ready = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.imem_rsp_err = 1'b0;

    // Reset held with memory responses toggling.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reset id_valid", 64'(bus.id_valid), 64'd0);
      chk("reset req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("reset pc_hold", 64'(bus.pc_hold), 64'd1);
      chk("reset id_pc", bus.id_pc, 64'd0);
      chk("reset id_inst", 64'(bus.id_inst), 64'd0);
      chk("reset id_fault", 64'(bus.id_fault), 64'd0);
    end

    // Release and stream eight instructions through a zero-wait memory.
    rst_r = 1'b1; lat = 1; budget = 8; data_mode = 1'b0; run_max = 0;
    for (int i = 0; i < 8; i++) push_exp(64'h8000_0000 + 64'(4 * i), 32'h0000_0013, 1'b0);
    step();
    chk("first req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("first req_addr", bus.imem_req_addr, 64'h8000_0000);
    drain("stream");
    chk("stream consecutive id_valid", 64'(run_max), 64'd8);

    // Decode back-pressure for five cycles.
    data_mode = 1'b1; id_ready_r = 1'b0; budget = 6; fires = 0;
    for (int i = 0; i < 6; i++) push_exp(64'h8000_0020 + 64'(4 * i), {16'h0020 + 16'(4 * i), 16'h0013}, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i >= 3) begin
        chk("bp pc_hold", 64'(bus.pc_hold), 64'd1);
        chk("bp id_valid", 64'(bus.id_valid), 64'd1);
        chk("bp id_pc stable", bus.id_pc, 64'h8000_0020);
      end
    end
    chk("bp requests issued", 64'(fires), 64'd2);
    id_ready_r = 1'b1;
    drain("backpressure");

    // Flush with two requests in flight on a 3-cycle memory.
    lat = 3; budget = 2; fires = 0;
    for (int n = 0; n < 10 && fires < 2; n++) step();
    chk("flush setup requests", 64'(fires), 64'd2);
    flush_r = 1'b1; flush_tgt = 64'h8000_0100;
    step();
    chk("flush cycle req_valid", 64'(bus.imem_req_valid), 64'd0);
    flush_r = 1'b0; budget = 3;
    push_exp(64'h8000_0100, 32'h0100_0013, 1'b0);
    push_exp(64'h8000_0104, 32'h0104_0013, 1'b0);
    push_exp(64'h8000_0108, 32'h0108_0013, 1'b0);
    drain("flush");

    // Access fault on 0x80000008 only.
    lat = 1; flush_r = 1'b1; flush_tgt = 64'h8000_0004;
    step();
    flush_r = 1'b0; err_en = 1'b1; budget = 3;
    push_exp(64'h8000_0004, 32'h0004_0013, 1'b0);
    push_exp(64'h8000_0008, 32'h0008_0013, 1'b1);
    push_exp(64'h8000_000C, 32'h000C_0013, 1'b0);
    drain("fault");
    err_en = 1'b0;

    // Memory not ready for four cycles.
    stall_r = 1'b1; budget = 1;
    push_exp(64'h8000_0010, 32'h0010_0013, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall pc_hold", 64'(bus.pc_hold), 64'd1);
      chk("stall req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("stall req_addr", bus.imem_req_addr, 64'h8000_0010);
    end
    stall_r = 1'b0;
    drain("stall");

    // Reset asserted with instructions buffered.
    id_ready_r = 1'b0; budget = 2;
    repeat (4) step();
    chk("pre-reset id_valid", 64'(bus.id_valid), 64'd1);
    rst_r = 1'b0; budget = 0;
    step();
    chk("mid reset id_valid", 64'(bus.id_valid), 64'd0);
    chk("mid reset pc_hold", 64'(bus.pc_hold), 64'd1);
    chk("mid reset req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("mid reset id_pc", bus.id_pc, 64'd0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit sitting directly downstream of the PC-generation stage. Each cycle it takes the current fetch address, issues an instruction-memory request on a valid/ready channel, and tracks in-flight requests. It buffers in-order responses in a small FIFO and presents instruction, PC and fault status to decode. It also back-pressures the PC register (`pc_hold`) and drops stale responses after a control-flow redirect (`flush`).

## Interface
Parameters:
- `ADDR_W`, 64: fetch address width; matches `INST_ADDR_BUS`.
- `INST_W`, 32: instruction width.
- `DEPTH`, 2: maximum of (in-flight requests + buffered instructions); power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_W  current fetch address from the PC register.
- `flush`  in  1  redirect this cycle; `pc` holds the new target from the next cycle.
- `pc_hold`  out  1  PC register must not advance this cycle.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  ADDR_W  request address (= `pc`).
- `imem_rsp_valid`  in  1  response valid, in request order, always accepted.
- `imem_rsp_data`  in  INST_W  instruction word.
- `imem_rsp_err`  in  1  access fault for this response.
- `id_valid`  out  1  instruction available to decode.
- `id_ready`  in  1  decode consumes.
- `id_inst`  out  INST_W  instruction.
- `id_pc`  out  ADDR_W  address of `id_inst`.
- `id_fault`  out  1  access fault flag.

## Operation
- Counters (registered): `out_cnt` (issued, unanswered, 0..DEPTH), `disc_cnt` (in-flight responses to drop, ≤ `out_cnt`), `fifo_cnt` (0..DEPTH).
- `deq = id_valid & id_ready`. Credit: `out_cnt + fifo_cnt - deq < DEPTH`.
- `imem_req_valid = rst & credit & ~flush`. `imem_req_addr = pc`.
- `pc_hold = ~(imem_req_valid & imem_req_ready)`.
- On request handshake: push `pc` into a DEPTH-entry PC tracking queue and increment `out_cnt`.
- On response: pop the tracking queue and decrement `out_cnt`.
  - If `disc_cnt > 0` or `flush` is high this cycle: drop the response and decrement `disc_cnt` if nonzero.
  - Otherwise enqueue {data, popped pc, err} into the FIFO.
- `flush`:
  - FIFO is cleared next cycle.
  - `disc_cnt <= out_cnt` after this cycle's response retirement; no request is issued in the flush cycle.
  - A `deq` in the flush cycle is still a valid consume.
- Credit counts discarded in-flight requests. Fetch resumes at the new `pc` the cycle after `flush`, given credit.
- Simultaneous enqueue and dequeue with a full FIFO is legal; the count is unchanged.

## Timing
- Reset values: `id_valid=0`, `imem_req_valid=0`, `pc_hold=1`, `id_inst/id_pc/id_fault=0`, all counters 0, queues empty.
- Response to `id_valid`: 1 cycle (FIFO registered, no bypass).
- With a zero-wait memory (response the cycle after request) and `id_ready=1`: one instruction per cycle sustained with DEPTH=2.
- `id_*` are stable while `id_valid & ~id_ready`, except on `flush`, which drops `id_valid` next cycle.
- Reset asserted mid-operation clears everything asynchronously. Memory responses after reset release are a system error; no handling is required.

## Structure
- `defines.v` supplies `INST_ADDR_BUS`, `INST_ADDR_SIZE`, and a new `` `INST_BUS `` (31:0).
- Sub-module `if_fetch_fifo`: synchronous FIFO with DEPTH entries, count output and `clr` input.
  - Instantiated twice: PC tracking queue (width ADDR_W) and instruction buffer (width INST_W+ADDR_W+1).
- Top-level holds the credit and discard logic.

## Test plan
- Reset: hold `rst=0` with `imem_rsp_valid` toggling -> `id_valid=0`, `imem_req_valid=0`, `pc_hold=1`. Release -> request for `pc=0x8000_0000` in the first cycle.
- Streaming: zero-wait memory returns `0x00000013` for PCs 0x80000000..0x8000001C, `id_ready=1` -> 8 consecutive `id_valid` cycles with matching `id_pc`.
- Backpressure: `id_ready=0` for 5 cycles -> at most 2 requests issued, `pc_hold=1` thereafter, no instruction lost or reordered on release.
- Flush with 2 outstanding: memory latency 3, `flush` at `pc=0x80000100` -> the 2 stale responses are dropped, and the first `id_pc` after the flush is 0x80000100.
- Fault: `imem_rsp_err=1` for `pc=0x80000008` -> `id_fault=1` with that `id_pc`; neighbouring entries have `id_fault=0`.
- Request stall: `imem_req_ready=0` for 4 cycles -> `pc_hold=1` and `imem_req_addr` stable throughout.
